rs_issue_scheduler: RTL

//  Controls an array of N reservation-station entries. Each cycle it:
//  - picks a free entry for the dispatched instruction and drives that entry's wr_en;
//  - picks one ready entry to issue and drives that entry's clear;
//  - registers the issue choice for the issue/execute pipeline register.

---
 rtl/rs_issue_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler.
// Allocates the lowest free RS entry to a dispatched instruction, picks one
// ready entry to issue each cycle, and registers the issue choice for the
// IS/EX pipeline register.
// Optional build macro: RS_AGE_ORDER_EN selects oldest-first issue using an
// age matrix; when undefined, issue order is round-robin from rr_ptr.
module rs_issue_scheduler #(
  parameter int RS_LEN = 8,
  parameter int IDX_W  = $clog2(RS_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_squash,
  input  logic              i_dispatch_req,
  input  logic              i_fu_avail,
  input  logic [RS_LEN-1:0] i_entry_busy,
  input  logic [RS_LEN-1:0] i_entry_ready,
  output logic [RS_LEN-1:0] o_entry_wr_en,
  output logic [RS_LEN-1:0] o_entry_clear,
  output logic              o_dispatch_ack,
  output logic              o_rs_full,
  output logic [IDX_W:0]    o_free_count,
  output logic              o_issue_valid,
  output logic [IDX_W-1:0]  o_issue_idx
);

  localparam logic [RS_LEN-1:0] ONE_HOT0 = {{(RS_LEN-1){1'b0}}, 1'b1};

  logic              w_flush;
  logic [RS_LEN-1:0] w_cand;
  logic              w_alloc_found;
  logic [IDX_W-1:0]  w_alloc_idx;
  logic [IDX_W:0]    w_free_count;
  logic              w_sel_found;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_issue;
  logic              r_issue_valid;
  logic [IDX_W-1:0]  r_issue_idx;

  assign w_flush = reset | i_squash;
  assign w_cand  = i_entry_ready & i_entry_busy;

  // Lowest-index free entry and count of free entries.
  always_comb begin
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    w_free_count  = '0;
    for (int k = 0; k < RS_LEN; k++) begin
      w_free_count = w_free_count + (IDX_W+1)'(!i_entry_busy[k]);
      if (!w_alloc_found && !i_entry_busy[k]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = IDX_W'(k);
      end else begin
        w_alloc_found = w_alloc_found;
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // r_older[j][k] = 1 means entry j was dispatched before entry k.
  logic [RS_LEN-1:0] r_older [RS_LEN];
  logic              w_blocked;

  // Oldest ready candidate: one that no other candidate is older than.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_blocked   = 1'b0;
    for (int i = 0; i < RS_LEN; i++) begin
      w_blocked = 1'b0;
      for (int j = 0; j < RS_LEN; j++) begin
        w_blocked = w_blocked | (w_cand[j] & r_older[j][i]);
      end
      if (!w_sel_found && w_cand[i] && !w_blocked) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Age matrix: on alloc of k, every currently busy entry becomes older than k.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      for (int j = 0; j < RS_LEN; j++) begin
        r_older[j] <= '0;
      end
    end else if (o_dispatch_ack) begin
      for (int j = 0; j < RS_LEN; j++) begin
        r_older[j][w_alloc_idx] <= i_entry_busy[j];
      end
      r_older[w_alloc_idx] <= '0;
    end else begin
      for (int j = 0; j < RS_LEN; j++) begin
        r_older[j] <= r_older[j];
      end
    end
  end
`else
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_probe;

  // Round-robin: first candidate at or after rr_ptr, wrapping around.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_probe     = '0;
    for (int k = 0; k < RS_LEN; k++) begin
      w_probe = r_rr_ptr + IDX_W'(k);
      if (!w_sel_found && w_cand[w_probe]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_probe;
      end else begin
        w_sel_found = w_sel_found;
      end
    end
  end

  // Round-robin pointer advances past the entry that just issued.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_rr_ptr <= '0;
    end else if (w_issue) begin
      r_rr_ptr <= w_sel_idx + IDX_W'(1);
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign w_issue        = i_fu_avail & w_sel_found & ~w_flush;
  assign o_dispatch_ack = i_dispatch_req & w_alloc_found & ~w_flush;
  assign o_entry_wr_en  = o_dispatch_ack ? (ONE_HOT0 << w_alloc_idx) : '0;
  assign o_entry_clear  = w_issue ? (ONE_HOT0 << w_sel_idx) : '0;
  assign o_rs_full      = &i_entry_busy;
  assign o_free_count   = w_free_count;

  // Issue pipeline register; the index holds when nothing issues.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
    end else if (w_issue) begin
      r_issue_valid <= 1'b1;
      r_issue_idx   <= w_sel_idx;
    end else begin
      r_issue_valid <= 1'b0;
      r_issue_idx   <= r_issue_idx;
    end
  end

  assign o_issue_valid = r_issue_valid;
  assign o_issue_idx   = r_issue_idx;

endmodule
